// File: rtl/lcd_mmio_controller.sv
// rtl/lcd_mmio_controller.sv - memory-mapped HD44780-style LCD write controller
//
// Turns CPU stores into timed LCD bus writes (RS/DATA setup, EN pulse, hold,
// execution wait). One write is held pending so the core never stalls.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_lcd_sel, i_wren   region select and store strobe
//   i_addr[3:2]         register: 0=CMD 1=DATA 2=CTRL 3=STATUS
//   i_wdata             store data
//   o_rdata             combinational read data (0 when not selected)
//   o_lcd_*             DE2 LCD pins (data, rs, rw, en, on, blon)

module lcd_mmio_controller #(
  parameter int T_SETUP = 3,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 3,
  parameter int T_WAIT  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_sel,
  input  logic        i_wren,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_blon
);

  localparam int MAX_WAIT = (T_CLR > T_WAIT) ? T_CLR : T_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  // Counter reload values: each phase lasts (count + 1) cycles.
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_WAIT  = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(T_CLR - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cur_long;

  logic          pending;
  logic          pend_rs;
  logic [7:0]    pend_data;
  logic          pend_long;
  logic          overrun;

  logic [1:0]    reg_sel;
  logic          wr;
  logic          push;
  logic          pop;
  logic          ctrl_wr;
  logic          status_wr;
  logic          is_long;
  logic          busy;
  logic          unused_bits;

  assign reg_sel   = i_addr[3:2];
  assign wr        = i_lcd_sel & i_wren;
  assign push      = wr & ~reg_sel[1];
  assign ctrl_wr   = wr & (reg_sel == 2'd2);
  assign status_wr = wr & (reg_sel == 2'd3);
  assign pop       = (state == ST_IDLE) & pending;
  assign busy      = (state != ST_IDLE);
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_long   = (reg_sel == 2'd0) &&
                     (i_wdata[7:0] == 8'h01 || i_wdata[7:0] == 8'h02 ||
                      i_wdata[7:0] == 8'h03);
  assign unused_bits = ^{i_addr[1:0], i_wdata[31:8]};

  assign o_lcd_rw = 1'b0;

  always_comb begin
    o_rdata = '0;
    if (i_lcd_sel) begin
      case (reg_sel)
        2'd2:    o_rdata = {30'b0, o_lcd_blon, o_lcd_on};
        2'd3:    o_rdata = {29'b0, overrun, pending, busy};
        default: o_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cur_long   <= 1'b0;
      pending    <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= 8'h00;
      pend_long  <= 1'b0;
      overrun    <= 1'b0;
      o_lcd_data <= 8'h00;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_blon <= 1'b0;
    end else begin
      // Pending slot: a pop frees the slot in the same edge, so a write
      // arriving together with a pop is accepted rather than dropped.
      if (push && (!pending || pop)) begin
        pending   <= 1'b1;
        pend_rs   <= reg_sel[0];
        pend_data <= i_wdata[7:0];
        pend_long <= is_long;
      end else if (pop) begin
        pending <= 1'b0;
      end

      // Setting overrun takes priority over a STATUS-write clear.
      if (push && pending && !pop) begin
        overrun <= 1'b1;
      end else if (status_wr) begin
        overrun <= 1'b0;
      end

      if (ctrl_wr) begin
        o_lcd_on   <= i_wdata[0];
        o_lcd_blon <= i_wdata[1];
      end

      case (state)
        ST_IDLE: begin
          if (pending) begin
            o_lcd_data <= pend_data;
            o_lcd_rs   <= pend_rs;
            cur_long   <= pend_long;
            cnt        <= L_SETUP;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b1;
            cnt      <= L_EN;
            state    <= ST_PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b0;
            cnt      <= L_HOLD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= cur_long ? L_CLR : L_WAIT;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          o_lcd_en <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_mmio_controller.sv
// tb/tb_lcd_mmio_controller.sv - self-checking bench for lcd_mmio_controller

module tb_lcd_mmio_controller;

  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_WAIT  = 10;
  localparam int P_CLR   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

  always #5 clk = ~clk;

  lcd_mmio_controller #(
    .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
    .T_WAIT(P_WAIT), .T_CLR(P_CLR)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_lcd_sel(sel), .i_wren(wren),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_en(lcd_en), .o_lcd_on(lcd_on), .o_lcd_blon(lcd_blon)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a transfer is a span of cycles; EN is high for the
  // slice [P_SETUP, P_SETUP+P_EN) measured from the first busy cycle.
  int         m_rem, m_len;
  logic       m_rs, m_pend, m_prs, m_plong, m_ovr, m_on, m_blon;
  logic [7:0] m_data, m_pdata;

  logic [31:0] last_rdata;
  logic        last_en, last_on, last_blon, prev_en;
  logic [31:0] last_bus;
  logic [8:0]  seen[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_len = 0; m_rs = 0; m_data = 0;
    m_pend = 0; m_prs = 0; m_pdata = 0; m_plong = 0;
    m_ovr = 0; m_on = 0; m_blon = 0;
  endtask

  function automatic logic model_en();
    int el;
    el = m_len - m_rem;
    return (m_rem > 0) && (el >= P_SETUP) && (el < P_SETUP + P_EN);
  endfunction

  function automatic logic [31:0] model_rdata(input logic s, input logic [3:0] a);
    if (!s) return 32'h0;
    case (a[3:2])
      2'd2:    return {30'b0, m_blon, m_on};
      2'd3:    return {29'b0, m_ovr, m_pend, (m_rem > 0)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
    logic wr, push, pop, ovr_set;
    wr      = s & w;
    push    = wr && (a[3:2] < 2);
    pop     = (m_rem == 0) && m_pend;
    ovr_set = push && m_pend && !pop;
    if (m_rem > 0) m_rem--;
    if (pop) begin
      m_rs   = m_prs;
      m_data = m_pdata;
      m_len  = P_SETUP + P_EN + P_HOLD + (m_plong ? P_CLR : P_WAIT);
      m_rem  = m_len;
      m_pend = 0;
    end
    if (push && !ovr_set) begin
      m_pend  = 1;
      m_prs   = a[2];
      m_pdata = d[7:0];
      m_plong = (a[3:2] == 0) && (d[7:0] >= 1) && (d[7:0] <= 3);
    end
    if (ovr_set) m_ovr = 1;
    else if (wr && a[3:2] == 3) m_ovr = 0;
    if (wr && a[3:2] == 2) begin
      m_on   = d[0];
      m_blon = d[1];
    end
  endtask

  // One clock cycle: drive at the falling edge, compare, then clock the model.
  task automatic step(input logic s, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic r);
    logic [31:0] exp_bus;
    @(negedge clk);
    rst = r; sel = s; wren = w; addr = a; wdata = d;
    if (r) model_reset();
    #1;
    last_bus = 32'({lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_on, lcd_blon});
    exp_bus  = 32'({model_en(), m_rs, m_data, 1'b0, m_on, m_blon});
    check("bus_pins", last_bus, exp_bus);
    check("rdata", rdata, model_rdata(s, a));
    last_rdata = rdata; last_en = lcd_en; last_on = lcd_on; last_blon = lcd_blon;
    if (lcd_en && !prev_en) seen.push_back({lcd_rs, lcd_data});
    prev_en = lcd_en;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(s, w, a, d);
  endtask

  // Read STATUS until one transfer completes; stops at the first idle cycle.
  task automatic measure(output int busy_n, output int en_n, output int en_first);
    logic started;
    busy_n = 0; en_n = 0; en_first = -1; started = 0;
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 4'hC, 0, 0);
      if (last_rdata[0]) begin
        started = 1;
        if (last_en) begin
          if (en_first < 0) en_first = busy_n;
          en_n++;
        end
        busy_n++;
      end else if (started) begin
        break;
      end
    end
  endtask

  task automatic wait_en();
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 4'hC, 0, 0);
      if (last_en) break;
    end
    check("wait_en_timeout", 32'(last_en), 32'd1);
  endtask

  typedef struct {
    logic        sel;
    logic        wren;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_on;
    logic        exp_blon;
  } vec_t;

  vec_t tbl[13];
  int   bn, en, ef;

  initial begin
    model_reset();
    prev_en = 0;

    tbl[0]  = '{1'b1, 1'b0, 4'h8, 32'h0,  32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hC, 32'h0,  32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h8, 32'h3,  32'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'h8, 32'h0,  32'h3, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'h8, 32'h0,  32'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 4'h8, 32'h0,  32'h3, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 32'h0,  32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'h4, 32'h0,  32'h0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'h8, 32'h2,  32'h3, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 4'h8, 32'h0,  32'h2, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 32'h55, 32'h0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'hC, 32'h0,  32'h0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'hC, 32'h0,  32'h0, 1'b0, 1'b1};

    // Reset state
    step(1, 0, 4'hC, 0, 1);
    check("reset_status", last_rdata, 32'h0);
    check("reset_pins", last_bus, 32'h0);
    step(1, 0, 4'h8, 0, 1);
    check("reset_ctrl", last_rdata, 32'h0);
    step(0, 0, 4'h0, 0, 0);

    // Register access table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].sel, tbl[i].wren, tbl[i].addr, tbl[i].wdata, 0);
      check($sformatf("tbl%0d_rdata", i), last_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_onbl", i), {30'b0, last_blon, last_on},
            {30'b0, tbl[i].exp_blon, tbl[i].exp_on});
    end

    // Normal command timing
    step(1, 1, 4'h0, 32'h38, 0);
    measure(bn, en, ef);
    check("cmd38_busy", bn, 18);
    check("cmd38_en_len", en, 4);
    check("cmd38_en_start", ef, 2);
    check("cmd38_bus", {23'b0, lcd_rs, lcd_data}, 32'h038);

    // Long wait for clear, normal for 0x30
    step(1, 1, 4'h0, 32'h01, 0);
    measure(bn, en, ef);
    check("clr_busy", bn, 58);
    step(1, 1, 4'h0, 32'h30, 0);
    measure(bn, en, ef);
    check("cmd30_busy", bn, 18);

    // Back-to-back: second write arrives during the first EN pulse
    seen.delete();
    step(1, 1, 4'h4, 32'h41, 0);
    wait_en();
    step(1, 1, 4'h4, 32'h42, 0);
    step(1, 0, 4'hC, 0, 0);
    check("b2b_ovr_pend", 32'(last_rdata[2:1]), 32'h1);
    measure(bn, en, ef);
    check("b2b_idle_pending", 32'(last_rdata[2:1]), 32'h1);
    measure(bn, en, ef);
    check("b2b_second_busy", bn, 18);
    check("b2b_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("b2b_first", 32'(seen[0]), 32'h141);
      check("b2b_second", 32'(seen[1]), 32'h142);
    end

    // Overflow: third write is dropped
    seen.delete();
    step(1, 1, 4'h4, 32'h41, 0);
    step(1, 1, 4'h4, 32'h42, 0);
    step(1, 1, 4'h4, 32'h43, 0);
    step(1, 0, 4'hC, 0, 0);
    check("ovf_status", last_rdata, 32'h7);
    measure(bn, en, ef);
    measure(bn, en, ef);
    check("ovf_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("ovf_first", 32'(seen[0]), 32'h141);
      check("ovf_second", 32'(seen[1]), 32'h142);
    end
    step(1, 1, 4'hC, 0, 0);
    step(1, 0, 4'hC, 0, 0);
    check("ovf_cleared", last_rdata, 32'h0);

    // Reset in the middle of the EN pulse
    step(1, 1, 4'h8, 32'h3, 0);
    step(1, 1, 4'h4, 32'h55, 0);
    step(1, 1, 4'h4, 32'h56, 0);
    wait_en();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    check("async_rst_pins", 32'({lcd_en, lcd_on, lcd_blon}), 32'h0);
    step(1, 0, 4'hC, 0, 1);
    step(1, 0, 4'hC, 0, 0);
    check("post_rst_status", last_rdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, w;
      logic [3:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[7:0] = 8'($urandom_range(1, 3));
      step(s, w, a, d, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_mmio_controller.md
Name: lcd_mmio_controller

Overview:
- Memory-mapped responder for the LCD I/O region (0x1000_4000–0x1000_4FFF).
- The LSU presents a decoded select plus write strobe. The block turns each CPU write into a timed HD44780-style bus transaction (RS/RW/DATA setup, EN pulse, hold, execution wait) on the DE2 LCD pins.
- It holds one pending write so the single-cycle core never stalls, and returns status/control on reads.

Parameters:
- T_SETUP, 3, clock cycles RS/DATA are stable before EN rises (≥1)
- T_EN, 25, clock cycles EN is held high (≥1)
- T_HOLD, 3, clock cycles RS/DATA are held after EN falls (≥1)
- T_WAIT, 2000, post-transfer execution wait for normal command/data (≥1)
- T_CLR, 82000, post-transfer wait for clear/home commands (≥1)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_lcd_sel  in  1  LCD region select from address decoder
- i_wren  in  1  store strobe
- i_addr  in  4  byte offset within region; [3:2] selects register
- i_wdata  in  32  store data
- o_rdata  out  32  combinational read data; 0 when i_lcd_sel=0
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select (0=cmd, 1=data)
- o_lcd_rw  out  1  always 0 (write-only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power
- o_lcd_blon  out  1  backlight

Behaviour:
- Register map (by i_addr[3:2]):
  - 0 = CMD: write; wdata[7:0] queued with RS=0.
  - 1 = DATA: write; wdata[7:0] queued with RS=1.
  - 2 = CTRL: R/W; bit0 → o_lcd_on, bit1 → o_lcd_blon.
  - 3 = STATUS: reads {29'b0, overrun, pending, busy}; any write clears overrun.
- Reads of CMD/DATA return 0.
- A write is accepted on the rising edge where i_lcd_sel & i_wren = 1.
- Reset (async, immediate, any state):
  - All outputs 0.
  - FSM → IDLE, pending cleared, overrun=0, counter=0.
- Pending buffer (1 entry: {rs, byte, long}):
  - long=1 when the write is CMD with byte 0x01, 0x02 or 0x03.
  - A CMD/DATA write with pending empty loads the buffer.
  - A CMD/DATA write with pending full and no pop that cycle is dropped and sets overrun (sticky).
  - Pop and push in the same cycle: the new write is accepted and pending stays 1.
  - A STATUS write in the same cycle as an overrun event leaves overrun=1 (set wins).
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. busy = (state != IDLE).
  - IDLE: if pending=1, pop the buffer at the edge, register o_lcd_data/o_lcd_rs, load counter, enter SETUP.
  - SETUP: EN=0 for T_SETUP cycles → PULSE.
  - PULSE: EN=1 for exactly T_EN cycles → HOLD.
  - HOLD: EN=0 for T_HOLD cycles → WAIT.
  - WAIT: data/RS unchanged; (long ? T_CLR : T_WAIT) cycles → IDLE.
- Down-counter sizing and reload:
  - Width is $clog2(max(T_CLR, T_WAIT)+1).
  - Loaded with duration-1 on each state entry; the state exits when the counter is 0.
- Latency: write captured at edge N → SETUP entered at edge N+1 → EN rises at edge N+1+T_SETUP.
  - Total busy time per transfer: T_SETUP+T_EN+T_HOLD+(T_WAIT|T_CLR) cycles.
  - A transfer from pending starts the edge after the previous one returns to IDLE (one IDLE cycle between transfers).
- o_lcd_data/o_lcd_rs retain their last value in IDLE.
- o_lcd_en is glitch-free: driven from a register, never combinational.
- CTRL writes take effect at the write edge and are independent of FSM state.

Test Plan:
- Reset: assert i_reset → all o_lcd_* = 0; STATUS read = 0; CTRL read = 0.
- CMD 0x38 with small params (T_SETUP=2, T_EN=4, T_HOLD=2, T_WAIT=10, T_CLR=50):
  - o_lcd_rs=0, o_lcd_data=0x38 one edge after the write.
  - EN high exactly 4 cycles starting 2 cycles later.
  - busy=1 for 18 cycles, then 0.
- Back-to-back DATA 0x41 then 0x42 (second during PULSE of first):
  - STATUS.pending=1 until the first transfer finishes.
  - Second transfer shows rs=1, data=0x42, EN pulse after one IDLE cycle; overrun=0.
- Overflow: DATA 0x41, 0x42, 0x43 on consecutive cycles:
  - Only 0x41 and 0x42 appear on the bus; STATUS=0b111 during the first transfer.
  - Write STATUS → overrun=0.
- Clear cmd 0x01: WAIT lasts 50 cycles (busy for 58 total); cmd 0x30 uses 10.
- CTRL write 0x3 → o_lcd_on=o_lcd_blon=1, readback 0x3.
- Assert i_reset mid-PULSE → o_lcd_en=0 immediately (same cycle, no clock edge), pending cleared, on/blon=0.
- i_lcd_sel=0 with i_wren=1 → no state change; o_rdata=0.
